exec_seq: RTL and testbench
===========================

# exec_seq

Execution-phase sequencer for the MERA-400 CPU. It owns the state register (PP, W&, WE, WP, WR, WW, WM, WX, WA, WZ, FP) whose one-hot flags feed the P-D decoder. Inside every state it generates the STROB1 / STROB2 / GOT step pulses, and on GOT it takes the decoder's enter signals to pick the next state. It also runs the memory handshake for the WR and WW states and ends the instruction cycle (KC).

## Interface
- MEM_TIMEOUT, 255: maximum GOT-less wait in WR/WW, in clocks (1..255); expiry raises `alarm`.
- __clk  in  1  system clock, all state changes on rising edge.
- clm  in  1  reset, asynchronous, active-high.
- start  in  1  instruction fetched; starts a cycle in PP (ignored unless idle).
- ewa, ewp, ewe, ewr, ewm, eww, ewx, ewz, ew$  in  1 each  enter requests from decoder.
- efp  in  1  enter FP (floating/wide arithmetic hand-off).
- ekc  in  1  end-of-cycle request (decoder EKC*1 | EKC*2).
- mem_ok  in  1  memory transfer completed.
- fp_done  in  1  FP unit finished.
- pp, w$, we, wp, wr, ww, wm, wx, wa, wz, fp  out  1 each  one-hot state flags; all 0 when idle.
- strob1, strob2, got  out  1 each  step pulses.
- mem_req  out  1  memory request, WR/WW only.
- busy  out  1  any state flag set.
- kc  out  1  one-clock cycle-end pulse.
- alarm  out  1  one-clock pulse: sequencing error or memory timeout.

## Operation
- **Reset:** all outputs 0, sequencer idle, timeout counter 0. Reset mid-state aborts immediately with no `kc` and no `alarm`.
- **Step sequence per state.**
  - Short states (pp, w$, we, wp, wa, wz): S1 then GOT.
  - Long states (wx, wm): S1, S2, GOT.
  - Memory states (wr, ww): S1, MWAIT, S2, GOT.
  - fp: S1, FWAIT; no GOT.
- **Step outputs:** `strob1` is high in S1, `strob2` in S2, `got` in GOT.
- **MWAIT:** `mem_req` is high. Leave for S2 on the cycle after `mem_ok` is sampled high. Counter increments each MWAIT clock.
  - Counter reaching MEM_TIMEOUT: pulse `alarm` and `kc`, go idle.
  - `mem_ok` sampled in the same cycle the counter hits MEM_TIMEOUT: `mem_ok` wins.
  - Counter clears on entry to S1.
- **FWAIT:** on `fp_done`, pulse `kc` and go idle.
- **Decision at GOT** (the only cycle where ew*/efp/ekc are sampled):
  - Exactly one enter request → S1 of that state. Re-entering the same state is allowed.
  - `ekc` with no enter request → `kc` pulse, idle.
  - Two or more enter requests, or an enter request together with `ekc` → `alarm` + `kc`, idle.
  - Nothing asserted → `alarm` + `kc`, idle.
- **Idle:** the `start` pulse enters pp S1. `start` while busy is ignored.
- **State flags:** stay asserted for the whole state, including wait steps, and change on the same edge that enters the new S1.

## Timing
- The state following GOT has its S1 in the next clock; there are no dead cycles between states.
- Minimum cycle durations:
  - Short state: 2 clocks.
  - Long state: 3 clocks.
  - WR/WW with `mem_ok` at the first MWAIT clock: 4 clocks.
- `kc` and `alarm` are asserted in the clock after the deciding GOT / MWAIT / FWAIT edge, coincident with `busy` = 0.
- `start` arriving in the same clock as `kc` is ignored; it is accepted from the next clock on.
- All outputs are registered (no combinational path from inputs to outputs), except `mem_req`, which is decoded from the registered step.

## Test plan
- **Simple cycle:** reset, `start` at t0, `ekc` at pp GOT → pp high at t1..t2, `strob1` t1, `got` t2, `kc` t3, `busy` low t3.
- **Memory path:** `start` with `ewr` at pp GOT; `mem_ok` asserted in the 3rd MWAIT clock; `ew$` at wr GOT; `ekc` at w$ GOT → sequence pp(2) → wr(S1, 3×MWAIT with `mem_req`=1, S2, GOT) → w$(2) → `kc`; total 11 clocks.
- **Timeout:** MEM_TIMEOUT=4, enter ww, `mem_ok` never → `mem_req` high 4 clocks, then `alarm` = `kc` = 1 for one clock, all flags 0.
- **Conflict:** `ewa` + `ewp` both high at pp GOT → `alarm` and `kc` pulse together, no wa/wp flag ever set. Repeat with `ewe` + `ekc` → same result.
- **FP hand-off:** `efp` at pp GOT, `fp_done` after 10 clocks → fp flag high through the wait, `kc` on the following clock, no `got` during fp.
- **Reset mid-state:** assert `clm` during wx S2 → all outputs 0 asynchronously, no `kc`. After `clm` is released, `start` runs normally.

Source files
------------

// File: rtl/exec_seq.sv
// exec_seq: MERA-400 execution-phase sequencer. Holds the one-hot state flags (PP..FP),
//    emits the STROB1/STROB2/GOT step pulses, runs the WR/WW memory handshake and ends the cycle (KC).
// Latency: start -> pp+strob1 next clock; GOT decision -> next S1 (or kc/alarm) next clock; all outputs
//    are registered except mem_req, which is decoded from the registered step.
// Backpressure: WR/WW hold in MWAIT until mem_ok (bounded by MEM_TIMEOUT, then alarm+kc);
//    FP holds in FWAIT until fp_done; start is ignored while busy and in the kc clock.
//
// Ports:
//    __clk, clm           clock, asynchronous active-high reset
//    start                begin an instruction cycle in PP (idle only)
//    ew*, efp, ekc        decoder enter / end requests, sampled only in GOT
//    mem_ok, fp_done      memory transfer done (MWAIT), FP unit done (FWAIT)
//    pp..fp               one-hot state flags, all 0 when idle
//    strob1/strob2/got    step pulses
//    mem_req              memory request, high during MWAIT
//    busy, kc, alarm      any flag set, cycle-end pulse, error/timeout pulse

module exec_seq #(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic __clk,
   input  logic clm,
   input  logic start,
   input  logic ewa,
   input  logic ewp,
   input  logic ewe,
   input  logic ewr,
   input  logic ewm,
   input  logic eww,
   input  logic ewx,
   input  logic ewz,
   input  logic ew$,
   input  logic efp,
   input  logic ekc,
   input  logic mem_ok,
   input  logic fp_done,
   output logic pp,
   output logic w$,
   output logic we,
   output logic wp,
   output logic wr,
   output logic ww,
   output logic wm,
   output logic wx,
   output logic wa,
   output logic wz,
   output logic fp,
   output logic strob1,
   output logic strob2,
   output logic got,
   output logic mem_req,
   output logic busy,
   output logic kc,
   output logic alarm
);

   localparam logic [7:0] LP_TMO = MEM_TIMEOUT[7:0];

   typedef enum logic [3:0] {
      ST_IDLE = 4'd0,
      ST_PP   = 4'd1,
      ST_WS   = 4'd2,   // W&
      ST_WE   = 4'd3,
      ST_WP   = 4'd4,
      ST_WR   = 4'd5,
      ST_WW   = 4'd6,
      ST_WM   = 4'd7,
      ST_WX   = 4'd8,
      ST_WA   = 4'd9,
      ST_WZ   = 4'd10,
      ST_FP   = 4'd11
   } state_t;

   typedef enum logic [2:0] {
      SP_NONE  = 3'd0,
      SP_S1    = 3'd1,
      SP_S2    = 3'd2,
      SP_MWAIT = 3'd3,
      SP_FWAIT = 3'd4,
      SP_GOT   = 3'd5
   } step_t;

   // Flag vector bit order: pp, w$, we, wp, wr, ww, wm, wx, wa, wz, fp.
   localparam int F_PP = 0;
   localparam int F_WS = 1;
   localparam int F_WE = 2;
   localparam int F_WP = 3;
   localparam int F_WR = 4;
   localparam int F_WW = 5;
   localparam int F_WM = 6;
   localparam int F_WX = 7;
   localparam int F_WA = 8;
   localparam int F_WZ = 9;
   localparam int F_FP = 10;

   state_t      r_state;
   step_t       r_step;
   logic [7:0]  r_cnt;
   logic [10:0] r_flag;
   logic        r_strob1;
   logic        r_strob2;
   logic        r_got;
   logic        r_busy;
   logic        r_kc;
   logic        r_alarm;

   state_t      w_state_nx;
   step_t       w_step_nx;
   logic [7:0]  w_cnt_nx;
   logic [7:0]  w_cnt_inc;
   logic        w_kc_nx;
   logic        w_alarm_nx;
   logic [10:0] w_flag_nx;

   logic [9:0]  w_enter;
   logic        w_enter_any;
   logic        w_enter_one;
   state_t      w_target;

   // Enter requests in a vector; exactly one set bit is a legal request.
   assign w_enter     = {efp, ewz, ewa, ewx, ewm, eww, ewr, ewp, ewe, ew$};
   assign w_enter_any = |w_enter;
   assign w_enter_one = w_enter_any && ((w_enter & (w_enter - 10'd1)) == 10'd0);
   assign w_cnt_inc   = r_cnt + 8'd1;

   always_comb begin
      w_target = ST_IDLE;
      case (w_enter)
         10'b00_0000_0001: w_target = ST_WS;
         10'b00_0000_0010: w_target = ST_WE;
         10'b00_0000_0100: w_target = ST_WP;
         10'b00_0000_1000: w_target = ST_WR;
         10'b00_0001_0000: w_target = ST_WW;
         10'b00_0010_0000: w_target = ST_WM;
         10'b00_0100_0000: w_target = ST_WX;
         10'b00_1000_0000: w_target = ST_WA;
         10'b01_0000_0000: w_target = ST_WZ;
         10'b10_0000_0000: w_target = ST_FP;
         default:          w_target = ST_IDLE;
      endcase
   end

   // Next state / step, plus the kc/alarm pulses that go out with busy=0.
   always_comb begin
      w_state_nx = r_state;
      w_step_nx  = r_step;
      w_cnt_nx   = r_cnt;
      w_kc_nx    = 1'b0;
      w_alarm_nx = 1'b0;

      case (r_step)
         SP_NONE: begin
            // The kc clock still counts as the tail of the previous cycle.
            if (start && !r_kc) begin
               w_state_nx = ST_PP;
               w_step_nx  = SP_S1;
            end
         end

         SP_S1: begin
            case (r_state)
               ST_WR, ST_WW: w_step_nx = SP_MWAIT;
               ST_WX, ST_WM: w_step_nx = SP_S2;
               ST_FP:        w_step_nx = SP_FWAIT;
               default:      w_step_nx = SP_GOT;
            endcase
         end

         SP_MWAIT: begin
            // mem_ok takes priority over a timeout expiring in the same clock.
            if (mem_ok) begin
               w_step_nx = SP_S2;
            end else begin
               w_cnt_nx = w_cnt_inc;
               if (w_cnt_inc == LP_TMO) begin
                  w_state_nx = ST_IDLE;
                  w_step_nx  = SP_NONE;
                  w_kc_nx    = 1'b1;
                  w_alarm_nx = 1'b1;
               end
            end
         end

         SP_S2: begin
            w_step_nx = SP_GOT;
         end

         SP_FWAIT: begin
            if (fp_done) begin
               w_state_nx = ST_IDLE;
               w_step_nx  = SP_NONE;
               w_kc_nx    = 1'b1;
            end
         end

         SP_GOT: begin
            if (w_enter_one && !ekc) begin
               w_state_nx = w_target;
               w_step_nx  = SP_S1;
            end else begin
               // Plain ekc ends the cycle; anything else is a sequencing error.
               w_state_nx = ST_IDLE;
               w_step_nx  = SP_NONE;
               w_kc_nx    = 1'b1;
               w_alarm_nx = !(ekc && !w_enter_any);
            end
         end

         default: begin
            w_state_nx = ST_IDLE;
            w_step_nx  = SP_NONE;
         end
      endcase

      // The MWAIT budget restarts with every state entry.
      if (w_step_nx == SP_S1) begin
         w_cnt_nx = 8'd0;
      end
   end

   always_comb begin
      w_flag_nx       = '0;
      w_flag_nx[F_PP] = (w_state_nx == ST_PP);
      w_flag_nx[F_WS] = (w_state_nx == ST_WS);
      w_flag_nx[F_WE] = (w_state_nx == ST_WE);
      w_flag_nx[F_WP] = (w_state_nx == ST_WP);
      w_flag_nx[F_WR] = (w_state_nx == ST_WR);
      w_flag_nx[F_WW] = (w_state_nx == ST_WW);
      w_flag_nx[F_WM] = (w_state_nx == ST_WM);
      w_flag_nx[F_WX] = (w_state_nx == ST_WX);
      w_flag_nx[F_WA] = (w_state_nx == ST_WA);
      w_flag_nx[F_WZ] = (w_state_nx == ST_WZ);
      w_flag_nx[F_FP] = (w_state_nx == ST_FP);
   end

   always_ff @(posedge __clk or posedge clm) begin
      if (clm) begin
         r_state  <= ST_IDLE;
         r_step   <= SP_NONE;
         r_cnt    <= 8'd0;
         r_flag   <= '0;
         r_strob1 <= 1'b0;
         r_strob2 <= 1'b0;
         r_got    <= 1'b0;
         r_busy   <= 1'b0;
         r_kc     <= 1'b0;
         r_alarm  <= 1'b0;
      end else begin
         r_state  <= w_state_nx;
         r_step   <= w_step_nx;
         r_cnt    <= w_cnt_nx;
         r_flag   <= w_flag_nx;
         r_strob1 <= (w_step_nx == SP_S1);
         r_strob2 <= (w_step_nx == SP_S2);
         r_got    <= (w_step_nx == SP_GOT);
         r_busy   <= (w_state_nx != ST_IDLE);
         r_kc     <= w_kc_nx;
         r_alarm  <= w_alarm_nx;
      end
   end

   assign pp      = r_flag[F_PP];
   assign w$      = r_flag[F_WS];
   assign we      = r_flag[F_WE];
   assign wp      = r_flag[F_WP];
   assign wr      = r_flag[F_WR];
   assign ww      = r_flag[F_WW];
   assign wm      = r_flag[F_WM];
   assign wx      = r_flag[F_WX];
   assign wa      = r_flag[F_WA];
   assign wz      = r_flag[F_WZ];
   assign fp      = r_flag[F_FP];
   assign strob1  = r_strob1;
   assign strob2  = r_strob2;
   assign got     = r_got;
   assign mem_req = (r_step == SP_MWAIT);
   assign busy    = r_busy;
   assign kc      = r_kc;
   assign alarm   = r_alarm;

endmodule

// File: tb/tb_exec_seq.sv
// tb_exec_seq: randomized + directed bench for exec_seq with a queue scoreboard.
// Latency: expected per-clock outputs are queued when stimulus is built; a monitor pops one per presented clock.
// Backpressure: mem_ok / fp_done timing is chosen by the plan; start noise is injected while busy and in kc clocks.

module tb_exec_seq;

   localparam int TMO = 4;

   localparam int C_SHORT = 0;
   localparam int C_LONG  = 1;
   localparam int C_MEM   = 2;
   localparam int C_FP    = 3;

   localparam int D_NEXT = 0;
   localparam int D_EKC  = 1;
   localparam int D_NONE = 2;
   localparam int D_TWO  = 3;
   localparam int D_EKCX = 4;

   // Input vector: [0] start, [s] enter for state s (1..10), [11] ekc, [12] mem_ok, [13] fp_done.
   // Output vector: [10:0] flags by state index (0 pp,1 w$,2 we,3 wp,4 wr,5 ww,6 wm,7 wx,8 wa,9 wz,10 fp),
   //    [11] strob1, [12] strob2, [13] got, [14] mem_req, [15] busy, [16] kc, [17] alarm.
   localparam int B_S1 = 11, B_S2 = 12, B_GOT = 13, B_MREQ = 14, B_BUSY = 15, B_KC = 16, B_ALM = 17;

   typedef struct {
      int st;
      int wt;
      int dec;
      int a;
      int b;
   } visit_t;

   logic        __clk = 1'b0;
   logic        clm;
   logic [13:0] in_vec;
   logic        o_pp, o_ws, o_we, o_wp, o_wr, o_ww, o_wm, o_wx, o_wa, o_wz, o_fp;
   logic        o_strob1, o_strob2, o_got, o_mem_req, o_busy, o_kc, o_alarm;
   logic [17:0] out_vec;

   int          n_chk = 0;
   int          n_bad = 0;
   int          n_step = 0;

   visit_t      plan[$];
   logic [13:0] drv_q[$];
   logic [17:0] exp_q[$];

   always #5 __clk = ~__clk;

   exec_seq #(.MEM_TIMEOUT(TMO)) dut (
      .__clk   (__clk),
      .clm     (clm),
      .start   (in_vec[0]),
      .ew$     (in_vec[1]),
      .ewe     (in_vec[2]),
      .ewp     (in_vec[3]),
      .ewr     (in_vec[4]),
      .eww     (in_vec[5]),
      .ewm     (in_vec[6]),
      .ewx     (in_vec[7]),
      .ewa     (in_vec[8]),
      .ewz     (in_vec[9]),
      .efp     (in_vec[10]),
      .ekc     (in_vec[11]),
      .mem_ok  (in_vec[12]),
      .fp_done (in_vec[13]),
      .pp      (o_pp),
      .w$      (o_ws),
      .we      (o_we),
      .wp      (o_wp),
      .wr      (o_wr),
      .ww      (o_ww),
      .wm      (o_wm),
      .wx      (o_wx),
      .wa      (o_wa),
      .wz      (o_wz),
      .fp      (o_fp),
      .strob1  (o_strob1),
      .strob2  (o_strob2),
      .got     (o_got),
      .mem_req (o_mem_req),
      .busy    (o_busy),
      .kc      (o_kc),
      .alarm   (o_alarm)
   );

   assign out_vec = {o_alarm, o_kc, o_busy, o_mem_req, o_got, o_strob2, o_strob1,
                     o_fp, o_wz, o_wa, o_wx, o_wm, o_ww, o_wr, o_wp, o_we, o_ws, o_pp};

   task automatic check(input string nm, input logic [17:0] act, input logic [17:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s got=%05h want=%05h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: every clock in which the DUT shows any output consumes one expected entry.
   always @(negedge __clk) begin
      logic [17:0] o;
      logic [17:0] e;
      o = out_vec;
      if (|o) begin
         n_step++;
         if (exp_q.size() == 0) begin
            n_chk++;
            n_bad++;
            $display("FAIL unexpected_output got=%05h want=none t=%0t", o, $time);
         end else begin
            e = exp_q.pop_front();
            check($sformatf("step%0d", n_step), o, e);
         end
      end
   end

   // Reference rules
   function automatic int cls(input int s);
      case (s)
         4, 5:    return C_MEM;
         6, 7:    return C_LONG;
         10:      return C_FP;
         default: return C_SHORT;
      endcase
   endfunction

   function automatic logic [17:0] fl_busy(input int s);
      logic [17:0] r;
      r = '0;
      r[s] = 1'b1;
      r[B_BUSY] = 1'b1;
      return r;
   endfunction

   function automatic logic [13:0] rnd();
      return 14'($urandom);
   endfunction

   function automatic visit_t mk(input int st, input int wt, input int dec, input int a, input int b);
      visit_t v;
      v.st = st; v.wt = wt; v.dec = dec; v.a = a; v.b = b;
      return v;
   endfunction

   task automatic push(input logic [17:0] e, input logic [13:0] v);
      exp_q.push_back(e);
      drv_q.push_back(v);
   endtask

   // Expand the current plan into per-clock inputs and expected outputs.
   task automatic build_txn();
      logic [13:0] v;
      logic [17:0] bf;
      logic [17:0] e;
      int          s;
      bit          done;
      bit          alm;
      v = rnd();
      v[0] = 1'b1;
      drv_q.push_back(v);
      done = 1'b0;
      alm  = 1'b0;
      for (int i = 0; i < plan.size() && !done; i++) begin
         s  = plan[i].st;
         bf = fl_busy(s);
         e = bf; e[B_S1] = 1'b1;
         push(e, rnd());
         case (cls(s))
            C_LONG: begin
               e = bf; e[B_S2] = 1'b1;
               push(e, rnd());
            end
            C_MEM: begin
               e = bf; e[B_MREQ] = 1'b1;
               if (plan[i].wt == 0) begin
                  for (int j = 1; j <= TMO; j++) begin
                     v = rnd(); v[12] = 1'b0;
                     push(e, v);
                  end
                  done = 1'b1;
                  alm  = 1'b1;
               end else begin
                  for (int j = 1; j <= plan[i].wt; j++) begin
                     v = rnd(); v[12] = (j == plan[i].wt);
                     push(e, v);
                  end
                  e = bf; e[B_S2] = 1'b1;
                  push(e, rnd());
               end
            end
            C_FP: begin
               for (int j = 1; j <= plan[i].wt; j++) begin
                  v = rnd(); v[13] = (j == plan[i].wt);
                  push(bf, v);
               end
               done = 1'b1;
            end
            default: ;
         endcase
         if (!done) begin
            v = rnd();
            v[11:1] = '0;
            case (plan[i].dec)
               D_NEXT: v[plan[i+1].st] = 1'b1;
               D_EKC:  begin v[11] = 1'b1; done = 1'b1; end
               D_NONE: begin done = 1'b1; alm = 1'b1; end
               D_TWO:  begin v[plan[i].a] = 1'b1; v[plan[i].b] = 1'b1; done = 1'b1; alm = 1'b1; end
               default: begin v[plan[i].a] = 1'b1; v[11] = 1'b1; done = 1'b1; alm = 1'b1; end
            endcase
            e = bf; e[B_GOT] = 1'b1;
            push(e, v);
         end
      end
      e = '0;
      e[B_KC]  = 1'b1;
      e[B_ALM] = alm;
      push(e, rnd());   // random start in the kc clock must be ignored
   endtask

   task automatic drive_all(input bit tail);
      while (drv_q.size() > 0) begin
         @(posedge __clk);
         #1;
         in_vec = drv_q.pop_front();
      end
      if (tail) begin
         @(posedge __clk);
         #1;
         in_vec = '0;
      end
   endtask

   task automatic random_plan();
      int nvis;
      int r;
      visit_t vt;
      plan.delete();
      nvis = $urandom_range(1, 5);
      for (int i = 0; i < nvis; i++) begin
         vt.st = (i == 0) ? 0 : $urandom_range(1, 10);
         vt.wt = 0;
         if (cls(vt.st) == C_MEM) vt.wt = $urandom_range(0, TMO);
         if (cls(vt.st) == C_FP)  vt.wt = $urandom_range(1, 12);
         vt.a = $urandom_range(1, 10);
         vt.b = (vt.a % 10) + 1;
         if (i < nvis - 1) begin
            vt.dec = D_NEXT;
         end else begin
            r = $urandom_range(0, 9);
            vt.dec = (r < 6) ? D_EKC : (r == 6) ? D_NONE : (r == 7) ? D_TWO : D_EKCX;
         end
         plan.push_back(vt);
      end
   endtask

   initial begin
      logic [13:0] v;
      logic [17:0] e;
      clm = 1'b1;
      in_vec = '0;
      #12;
      check("reset_state", out_vec, 18'h0);
      #10;
      clm = 1'b0;

      // Simple cycle: pp, ekc.
      plan.delete(); plan.push_back(mk(0, 0, D_EKC, 0, 0)); build_txn();
      // Memory path: pp -> wr (mem_ok on 3rd MWAIT) -> w$ -> kc.
      plan.delete();
      plan.push_back(mk(0, 0, D_NEXT, 0, 0));
      plan.push_back(mk(4, 3, D_NEXT, 0, 0));
      plan.push_back(mk(1, 0, D_EKC, 0, 0));
      build_txn();
      // Timeout in ww.
      plan.delete();
      plan.push_back(mk(0, 0, D_NEXT, 0, 0));
      plan.push_back(mk(5, 0, D_EKC, 0, 0));
      build_txn();
      // Conflicts: ewa+ewp, then ewe+ekc.
      plan.delete(); plan.push_back(mk(0, 0, D_TWO, 8, 3)); build_txn();
      plan.delete(); plan.push_back(mk(0, 0, D_EKCX, 2, 0)); build_txn();
      // Nothing asserted at GOT.
      plan.delete(); plan.push_back(mk(0, 0, D_NONE, 0, 0)); build_txn();
      // FP hand-off with fp_done on the 10th wait clock.
      plan.delete();
      plan.push_back(mk(0, 0, D_NEXT, 0, 0));
      plan.push_back(mk(10, 10, D_EKC, 0, 0));
      build_txn();
      // mem_ok on the timeout clock wins; counter restarts on re-entry.
      plan.delete();
      plan.push_back(mk(0, 0, D_NEXT, 0, 0));
      plan.push_back(mk(4, TMO, D_NEXT, 0, 0));
      plan.push_back(mk(4, TMO, D_NEXT, 0, 0));
      plan.push_back(mk(6, 0, D_EKC, 0, 0));
      build_txn();
      // Re-entry of the same state and a chain of short/long states.
      plan.delete();
      plan.push_back(mk(0, 0, D_NEXT, 0, 0));
      plan.push_back(mk(8, 0, D_NEXT, 0, 0));
      plan.push_back(mk(8, 0, D_NEXT, 0, 0));
      plan.push_back(mk(9, 0, D_NEXT, 0, 0));
      plan.push_back(mk(7, 0, D_NEXT, 0, 0));
      plan.push_back(mk(2, 0, D_NONE, 0, 0));
      build_txn();
      drive_all(1'b1);

      // Reset during wx S2: pp S1, pp GOT (ewx), wx S1, then clm mid-S2.
      v = rnd(); v[0] = 1'b1; drv_q.push_back(v);
      push(fl_busy(0) | (18'h1 << B_S1), rnd());
      v = rnd(); v[11:1] = '0; v[7] = 1'b1;
      push(fl_busy(0) | (18'h1 << B_GOT), v);
      push(fl_busy(7) | (18'h1 << B_S1), rnd());
      drive_all(1'b0);
      @(posedge __clk);
      #2;
      clm = 1'b1;
      in_vec = '0;
      #1;
      check("async_reset_mid_state", out_vec, 18'h0);
      repeat (3) @(posedge __clk);
      #2;
      clm = 1'b0;

      // Randomized back-to-back cycles.
      for (int t = 0; t < 80; t++) begin
         random_plan();
         build_txn();
      end
      drive_all(1'b1);

      repeat (6) @(posedge __clk);
      #2;
      n_chk++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain left=%0d want=0", exp_q.size());
      end
      e = out_vec;
      check("idle_at_end", e, 18'h0);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
